// File: rtl/fec_serializer.sv
// Serializes a coded FEC frame onto a single line: fixed preamble, frame MSB first, idle gap.
// Each bit is held for BAUD_DIV clocks. All outputs are registered.
module fec_serializer #(
   parameter int unsigned FRAME_WIDTH              = 96,
   parameter int unsigned PREAMBLE_WIDTH           = 8,
   parameter logic [PREAMBLE_WIDTH-1:0] PREAMBLE   = 8'b1010_1011,
   parameter int unsigned BAUD_DIV                 = 16,
   parameter int unsigned GAP_BITS                 = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [FRAME_WIDTH-1:0] frame_in,
   input  logic                   frame_valid,
   output logic                   frame_ready,
   output logic                   tx_bit,
   output logic                   tx_active,
   output logic                   bit_strobe,
   output logic                   frame_done
);

   localparam int unsigned BaudW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned MaxA    = (PREAMBLE_WIDTH > FRAME_WIDTH) ? PREAMBLE_WIDTH : FRAME_WIDTH;
   localparam int unsigned MaxBits = (MaxA > GAP_BITS) ? MaxA : GAP_BITS;
   localparam int unsigned BitW    = $clog2(MaxBits + 1);

   localparam logic [BaudW-1:0] BaudLast  = BaudW'(BAUD_DIV - 1);
   localparam logic [BitW-1:0]  PreLast   = BitW'(PREAMBLE_WIDTH - 1);
   localparam logic [BitW-1:0]  FrameLast = BitW'(FRAME_WIDTH - 1);
   localparam logic [BitW-1:0]  GapLast   = BitW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

   typedef enum logic [1:0] {StIdle, StPreamble, StData, StGap} state_e;

   state_e                    state;
   logic [BaudW-1:0]          baud_cnt;
   logic [BitW-1:0]           bit_cnt;
   logic [PREAMBLE_WIDTH-1:0] pre_sh;
   logic [FRAME_WIDTH-1:0]    data_sh;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         baud_cnt    <= '0;
         bit_cnt     <= '0;
         pre_sh      <= '0;
         data_sh     <= '0;
         tx_bit      <= 1'b0;
         tx_active   <= 1'b0;
         bit_strobe  <= 1'b0;
         frame_done  <= 1'b0;
         frame_ready <= 1'b0;
      end else begin
         bit_strobe <= 1'b0;
         frame_done <= 1'b0;
         unique case (state)
            StIdle: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (frame_valid && frame_ready) begin
                  // First preamble bit goes straight to the line; the rest shift out of pre_sh.
                  state       <= StPreamble;
                  data_sh     <= frame_in;
                  pre_sh      <= PREAMBLE << 1;
                  tx_bit      <= PREAMBLE[PREAMBLE_WIDTH-1];
                  tx_active   <= 1'b1;
                  bit_strobe  <= 1'b1;
                  frame_ready <= 1'b0;
               end else begin
                  frame_ready <= 1'b1;
               end
            end

            StPreamble: begin
               if (baud_cnt != BaudLast) begin
                  baud_cnt <= baud_cnt + BaudW'(1);
               end else begin
                  baud_cnt   <= '0;
                  bit_strobe <= 1'b1;
                  if (bit_cnt != PreLast) begin
                     bit_cnt <= bit_cnt + BitW'(1);
                     tx_bit  <= pre_sh[PREAMBLE_WIDTH-1];
                     pre_sh  <= pre_sh << 1;
                  end else begin
                     state   <= StData;
                     bit_cnt <= '0;
                     tx_bit  <= data_sh[FRAME_WIDTH-1];
                     data_sh <= data_sh << 1;
                  end
               end
            end

            StData: begin
               if (baud_cnt != BaudLast) begin
                  baud_cnt <= baud_cnt + BaudW'(1);
               end else begin
                  baud_cnt <= '0;
                  if (bit_cnt != FrameLast) begin
                     bit_cnt    <= bit_cnt + BitW'(1);
                     bit_strobe <= 1'b1;
                     tx_bit     <= data_sh[FRAME_WIDTH-1];
                     data_sh    <= data_sh << 1;
                  end else begin
                     bit_cnt   <= '0;
                     tx_bit    <= 1'b0;
                     tx_active <= 1'b0;
                     if (GAP_BITS > 0) begin
                        state <= StGap;
                     end else begin
                        state       <= StIdle;
                        frame_done  <= 1'b1;
                        frame_ready <= 1'b1;
                     end
                  end
               end
            end

            StGap: begin
               if (baud_cnt != BaudLast) begin
                  baud_cnt <= baud_cnt + BaudW'(1);
               end else begin
                  baud_cnt <= '0;
                  if (bit_cnt != GapLast) begin
                     bit_cnt <= bit_cnt + BitW'(1);
                  end else begin
                     bit_cnt     <= '0;
                     state       <= StIdle;
                     frame_done  <= 1'b1;
                     frame_ready <= 1'b1;
                  end
               end
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fec_serializer.sv
// Bench for fec_serializer: default instance plus a BAUD_DIV=2 / GAP_BITS=0 instance,
// both checked every cycle against a cycle-level timing model fed by a bit scoreboard.
module tb_fec_serializer;

   localparam int unsigned NB = 104;

   logic        clk = 1'b0;
   logic        reset;
   logic        fv0, fv1;
   logic [95:0] fin0, fin1;
   logic [1:0]  rdy, txb, act, stb, done;

   int unsigned cyc    = 0;
   int unsigned errors = 0;
   int unsigned checks = 0;
   bit          chk_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fec_serializer u_dut0 (
      .clk         (clk),
      .reset       (reset),
      .frame_in    (fin0),
      .frame_valid (fv0),
      .frame_ready (rdy[0]),
      .tx_bit      (txb[0]),
      .tx_active   (act[0]),
      .bit_strobe  (stb[0]),
      .frame_done  (done[0])
   );

   fec_serializer #(
      .BAUD_DIV (2),
      .GAP_BITS (0)
   ) u_dut1 (
      .clk         (clk),
      .reset       (reset),
      .frame_in    (fin1),
      .frame_valid (fv1),
      .frame_ready (rdy[1]),
      .tx_bit      (txb[1]),
      .tx_active   (act[1]),
      .bit_strobe  (stb[1]),
      .frame_done  (done[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model state per instance
   bit          m_ready [2];
   bit          m_busy  [2];
   bit          m_done  [2];
   bit          m_bit   [2];
   int unsigned m_start [2];
   int unsigned scnt    [2];
   bit          exp_q0[$];
   bit          exp_q1[$];

   always @(negedge clk) begin
      int unsigned d, g, rel, tot;
      logic        e_act, e_stb, e_txb, v;
      logic [95:0] f;
      logic [7:0]  pre;
      if (chk_en) begin
         pre = 8'b1010_1011;
         for (int i = 0; i < 2; i++) begin
            d     = (i == 0) ? 16 : 2;
            g     = (i == 0) ? 4 : 0;
            tot   = (NB + g) * d;
            rel   = cyc - m_start[i];
            e_act = m_busy[i] && (rel >= 1) && (rel <= NB * d);
            e_stb = e_act && (((rel - 1) % d) == 0);
            if (e_stb) begin
               if (i == 0) begin
                  check_eq("sb_nonempty0", 32'(exp_q0.size() > 0), 32'd1);
                  if (exp_q0.size() > 0) m_bit[i] = exp_q0.pop_front();
               end else begin
                  check_eq("sb_nonempty1", 32'(exp_q1.size() > 0), 32'd1);
                  if (exp_q1.size() > 0) m_bit[i] = exp_q1.pop_front();
               end
            end
            e_txb = e_act ? m_bit[i] : 1'b0;
            if (stb[i] === 1'b1) scnt[i]++;

            check_eq($sformatf("frame_ready%0d", i), 32'(rdy[i]), 32'(m_ready[i]));
            check_eq($sformatf("frame_done%0d", i), 32'(done[i]), 32'(m_done[i]));
            check_eq($sformatf("tx_active%0d", i), 32'(act[i]), 32'(e_act));
            check_eq($sformatf("bit_strobe%0d", i), 32'(stb[i]), 32'(e_stb));
            check_eq($sformatf("tx_bit%0d", i), 32'(txb[i]), 32'(e_txb));
            if (m_done[i]) check_eq($sformatf("strobe_count%0d", i), scnt[i], NB);

            // Advance model to next cycle using inputs the DUT samples at the coming edge
            v = (i == 0) ? fv0 : fv1;
            f = (i == 0) ? fin0 : fin1;
            m_done[i] = 1'b0;
            if (reset) begin
               m_ready[i] = 1'b0;
               m_busy[i]  = 1'b0;
               if (i == 0) exp_q0.delete();
               else exp_q1.delete();
            end else if (m_busy[i]) begin
               if (rel == tot) begin
                  m_busy[i]  = 1'b0;
                  m_ready[i] = 1'b1;
                  m_done[i]  = 1'b1;
               end
            end else if (m_ready[i] && v) begin
               m_busy[i]  = 1'b1;
               m_ready[i] = 1'b0;
               m_start[i] = cyc;
               scnt[i]    = 0;
               for (int k = 7; k >= 0; k--) begin
                  if (i == 0) exp_q0.push_back(pre[k]);
                  else exp_q1.push_back(pre[k]);
               end
               for (int k = 95; k >= 0; k--) begin
                  if (i == 0) exp_q0.push_back(f[k]);
                  else exp_q1.push_back(f[k]);
               end
            end else begin
               m_ready[i] = 1'b1;
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      fv0   = 1'b0;
      fv1   = 1'b0;
      fin0  = '0;
      fin1  = '0;
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      fork
         begin
            // Single frame, one-cycle valid
            fv0  = 1'b1;
            fin0 = 96'hF00F_0000_0000_0000_0000_0001;
            tick();
            fv0 = 1'b0;
            repeat (1740) tick();
            // Valid held, frame_in churns while busy; second frame presented in done cycle
            fv0  = 1'b1;
            fin0 = 96'h1234_5678_9ABC_DEF0_0F1E_2D3C;
            for (int j = 1; j < 1729; j++) begin
               tick();
               fin0 = {$urandom(), $urandom(), $urandom()};
            end
            tick();
            fin0 = 96'hA5A5_5A5A_C3C3_3C3C_FFFF_0001;
            tick();
            fin0 = {$urandom(), $urandom(), $urandom()};
            repeat (20) tick();
            fv0 = 1'b0;
            repeat (1740) tick();
            // Reset in the middle of a frame, then a clean frame
            fv0  = 1'b1;
            fin0 = 96'hDEAD_BEEF_CAFE_F00D_1357_9BDF;
            tick();
            fv0 = 1'b0;
            repeat (499) tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            repeat (3) tick();
            fv0  = 1'b1;
            fin0 = 96'h8000_0000_0000_0000_0000_0003;
            tick();
            fv0 = 1'b0;
            repeat (1740) tick();
         end
         begin
            // Fast instance: back-to-back frames with no gap
            fv1  = 1'b1;
            fin1 = 96'hF00F_0000_0000_0000_0000_0001;
            for (int j = 1; j < 209; j++) tick();
            tick();
            fin1 = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
            tick();
            fv1 = 1'b0;
            repeat (250) tick();
         end
      join
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
